// File: rtl/stream_serializer.sv
// Width downsizer for valid-ready streams: one wide word in, 1..NBEATS narrow beats out,
// lane 0 first, with o_last marking the final beat of each word.
module stream_serializer #(
    parameter  int DWIDTH = 8,
    parameter  int NBEATS = 4,
    localparam int LWIDTH = $clog2(NBEATS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DWIDTH*NBEATS-1:0] i_data,
    input  logic [LWIDTH-1:0]        i_len,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [DWIDTH-1:0]        o_data,
    output logic                     o_last,
    output logic                     o_valid,
    input  logic                     i_ready
);

    localparam logic [LWIDTH-1:0] LEN_MAX = LWIDTH'(NBEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state_p0, state_nx;
    logic [DWIDTH*NBEATS-1:0]   shift_p0, shift_nx;
    logic [LWIDTH-1:0]          len_p0, len_nx;
    logic [LWIDTH-1:0]          cnt_p0, cnt_nx;
    logic [LWIDTH-1:0]          cnt_inc;
    logic [LWIDTH-1:0]          len_in;
    logic [DWIDTH-1:0]          data_nx;
    logic                       last_nx;
    logic                       vld_nx;
    logic                       accept;
    logic [DWIDTH-1:0]          lanes [NBEATS];

    // Saturate a requested length to the last physical lane (only reachable for non-power-of-2 NBEATS).
    function automatic logic [LWIDTH-1:0] clamp_len(input logic [LWIDTH-1:0] len);
        if (int'(len) > NBEATS - 1)
            return LEN_MAX;
        return len;
    endfunction

    always_comb begin
        for (int k = 0; k < NBEATS; k++)
            lanes[k] = shift_p0[k*DWIDTH +: DWIDTH];
    end

    // A new word may enter while idle, or on the very edge the final beat is consumed.
    assign o_ready = ~rst && (state_p0 == IDLE || (i_ready && o_last));
    assign accept  = i_valid && o_ready;
    assign len_in  = clamp_len(i_len);
    assign cnt_inc = cnt_p0 + 1'b1;

    always_comb begin
        state_nx = state_p0;
        shift_nx = shift_p0;
        len_nx   = len_p0;
        cnt_nx   = cnt_p0;
        data_nx  = o_data;
        last_nx  = o_last;
        vld_nx   = o_valid;
        if (accept) begin
            state_nx = SEND;
            shift_nx = i_data;
            len_nx   = len_in;
            cnt_nx   = '0;
            data_nx  = i_data[DWIDTH-1:0];
            last_nx  = (len_in == '0);
            vld_nx   = 1'b1;
        end else if (state_p0 == SEND && i_ready) begin
            if (!o_last) begin
                cnt_nx  = cnt_inc;
                data_nx = lanes[cnt_inc];
                last_nx = (cnt_inc == len_p0);
            end else begin
                state_nx = IDLE;
                last_nx  = 1'b0;
                vld_nx   = 1'b0;
            end
        end
    end

    // Output stage: registered beat, its last flag and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            shift_p0 <= '0;
            len_p0   <= '0;
            cnt_p0   <= '0;
            o_data   <= '0;
            o_last   <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            state_p0 <= state_nx;
            shift_p0 <= shift_nx;
            len_p0   <= len_nx;
            cnt_p0   <= cnt_nx;
            o_data   <= data_nx;
            o_last   <= last_nx;
            o_valid  <= vld_nx;
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Directed and randomized bench for stream_serializer (DWIDTH=8, NBEATS=4).
module tb_stream_serializer;

    localparam int DWIDTH = 8;
    localparam int NBEATS = 4;
    localparam int LWIDTH = $clog2(NBEATS);

    logic                     clk = 1'b0;
    logic                     rst;
    logic [DWIDTH*NBEATS-1:0] i_data;
    logic [LWIDTH-1:0]        i_len;
    logic                     i_valid;
    logic                     o_ready;
    logic [DWIDTH-1:0]        o_data;
    logic                     o_last;
    logic                     o_valid;
    logic                     i_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;

    stream_serializer #(.DWIDTH(DWIDTH), .NBEATS(NBEATS)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_len(i_len), .i_valid(i_valid),
        .o_ready(o_ready), .o_data(o_data), .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready)
    );

    always #5 clk = ~clk;

    // Inputs are driven just after the falling edge; outputs are observed 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b1; i_data = 32'h12345678; i_len = 2'd3; i_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle(); #1;
            total_cnt++;
            if (o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== 8'h00 || o_ready !== 1'b0)
                $display("FAIL reset_c%0d got v=%b l=%b d=%h r=%b want v=0 l=0 d=00 r=0",
                         c, o_valid, o_last, o_data, o_ready);
            else pass_cnt++;
        end
        next_cycle();
        rst = 1'b0; i_valid = 1'b0;
    endtask

    task automatic test_full_word();
        logic [7:0] exp_d [4];
        exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        i_valid = 1'b1; i_data = 32'hDDCCBBAA; i_len = 2'd3; i_ready = 1'b1;
        #1;
        total_cnt++;
        if (o_ready !== 1'b1) $display("FAIL full_idle_ready got %b want 1", o_ready);
        else pass_cnt++;
        for (int b = 0; b < 4; b++) begin
            next_cycle(); i_valid = 1'b0; #1;
            total_cnt++;
            if (o_valid !== 1'b1 || o_data !== exp_d[b] || o_last !== (b == 3) || o_ready !== (b == 3))
                $display("FAIL full_beat%0d got v=%b d=%h l=%b r=%b want v=1 d=%h l=%b r=%b",
                         b, o_valid, o_data, o_last, o_ready, exp_d[b], b == 3, b == 3);
            else pass_cnt++;
        end
        next_cycle(); #1;
        total_cnt++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== 8'hDD)
            $display("FAIL full_idle got v=%b l=%b d=%h want v=0 l=0 d=dd", o_valid, o_last, o_data);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        i_valid = 1'b1; i_data = 32'h44332211; i_len = 2'd0; i_ready = 1'b1;
        next_cycle();
        i_data = 32'h00006655; i_len = 2'd1; #1;
        total_cnt++;
        if (o_valid !== 1'b1 || o_data !== 8'h11 || o_last !== 1'b1 || o_ready !== 1'b1)
            $display("FAIL b2b_single got v=%b d=%h l=%b r=%b want v=1 d=11 l=1 r=1",
                     o_valid, o_data, o_last, o_ready);
        else pass_cnt++;
        next_cycle(); i_valid = 1'b0; #1;
        total_cnt++;
        if (o_valid !== 1'b1 || o_data !== 8'h55 || o_last !== 1'b0)
            $display("FAIL b2b_beat0 got v=%b d=%h l=%b want v=1 d=55 l=0", o_valid, o_data, o_last);
        else pass_cnt++;
        next_cycle(); #1;
        total_cnt++;
        if (o_valid !== 1'b1 || o_data !== 8'h66 || o_last !== 1'b1)
            $display("FAIL b2b_beat1 got v=%b d=%h l=%b want v=1 d=66 l=1", o_valid, o_data, o_last);
        else pass_cnt++;
        next_cycle(); #1;
        total_cnt++;
        if (o_valid !== 1'b0) $display("FAIL b2b_idle got v=%b want 0", o_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [4];
        logic       rdy_seq [7];
        int         b;
        int         hs;
        exp_d   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        b = 0; hs = 0;
        i_valid = 1'b1; i_data = 32'hDDCCBBAA; i_len = 2'd3; i_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            next_cycle(); i_valid = 1'b0; i_ready = rdy_seq[k]; #1;
            total_cnt++;
            if (o_valid !== 1'b1 || o_data !== exp_d[b] || o_last !== (b == 3))
                $display("FAIL bp_cycle%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, o_valid, o_data, o_last, exp_d[b], b == 3);
            else pass_cnt++;
            if (o_valid && i_ready) begin
                hs++;
                if (b < 3) b++;
            end
        end
        next_cycle(); i_ready = 1'b1; #1;
        total_cnt++;
        if (o_valid !== 1'b0 || hs != 4)
            $display("FAIL bp_done got v=%b handshakes=%0d want v=0 handshakes=4", o_valid, hs);
        else pass_cnt++;
    endtask

    task automatic test_stall_last();
        i_valid = 1'b1; i_data = 32'h00002010; i_len = 2'd1; i_ready = 1'b1;
        next_cycle(); i_valid = 1'b0; #1;
        total_cnt++;
        if (o_data !== 8'h10 || o_last !== 1'b0) $display("FAIL stall_beat0 got d=%h l=%b want d=10 l=0", o_data, o_last);
        else pass_cnt++;
        next_cycle(); i_valid = 1'b1; i_data = 32'h00000077; i_len = 2'd0; i_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            total_cnt++;
            if (o_valid !== 1'b1 || o_data !== 8'h20 || o_last !== 1'b1 || o_ready !== 1'b0)
                $display("FAIL stall_hold%0d got v=%b d=%h l=%b r=%b want v=1 d=20 l=1 r=0",
                         c, o_valid, o_data, o_last, o_ready);
            else pass_cnt++;
            next_cycle();
        end
        i_ready = 1'b1; #1;
        total_cnt++;
        if (o_ready !== 1'b1 || o_data !== 8'h20) $display("FAIL stall_release got r=%b d=%h want r=1 d=20", o_ready, o_data);
        else pass_cnt++;
        next_cycle(); i_valid = 1'b0; #1;
        total_cnt++;
        if (o_valid !== 1'b1 || o_data !== 8'h77 || o_last !== 1'b1)
            $display("FAIL stall_newword got v=%b d=%h l=%b want v=1 d=77 l=1", o_valid, o_data, o_last);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_reset_midword();
        i_valid = 1'b1; i_data = 32'hDDCCBBAA; i_len = 2'd3; i_ready = 1'b1;
        next_cycle(); i_valid = 1'b0;
        next_cycle(); #1;
        total_cnt++;
        if (o_data !== 8'hBB) $display("FAIL midrst_bb got d=%h want bb", o_data);
        else pass_cnt++;
        next_cycle(); rst = 1'b1; #1;
        total_cnt++;
        if (o_ready !== 1'b0) $display("FAIL midrst_ready got r=%b want 0", o_ready);
        else pass_cnt++;
        next_cycle(); rst = 1'b0; #1;
        total_cnt++;
        if (o_valid !== 1'b0 || o_data !== 8'h00 || o_last !== 1'b0)
            $display("FAIL midrst_cleared got v=%b d=%h l=%b want v=0 d=00 l=0", o_valid, o_data, o_last);
        else pass_cnt++;
        i_valid = 1'b1; i_data = 32'h0000EEFF; i_len = 2'd1;
        next_cycle(); i_valid = 1'b0; #1;
        total_cnt++;
        if (o_valid !== 1'b1 || o_data !== 8'hFF || o_last !== 1'b0)
            $display("FAIL midrst_ff got v=%b d=%h l=%b want v=1 d=ff l=0", o_valid, o_data, o_last);
        else pass_cnt++;
        next_cycle(); #1;
        total_cnt++;
        if (o_valid !== 1'b1 || o_data !== 8'hEE || o_last !== 1'b1)
            $display("FAIL midrst_ee got v=%b d=%h l=%b want v=1 d=ee l=1", o_valid, o_data, o_last);
        else pass_cnt++;
        next_cycle(); #1;
        total_cnt++;
        if (o_valid !== 1'b0) $display("FAIL midrst_idle got v=%b want 0 (leftover beat)", o_valid);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [8:0]  sb [$];
        logic [8:0]  exp_beat;
        logic [31:0] w;
        int          errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            w       = $urandom;
            i_data  = w;
            i_len   = LWIDTH'($urandom_range(0, NBEATS - 1));
            i_valid = ($urandom_range(0, 9) < 7);
            i_ready = ($urandom_range(0, 9) < 7);
            if (c >= 370) i_valid = 1'b0;
            if (c >= 380) i_ready = 1'b1;
            #1;
            if (o_valid && i_ready) begin
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL rand_extra_beat got d=%h l=%b want no beat", o_data, o_last);
                    errs++;
                end else begin
                    exp_beat = sb.pop_front();
                    if ({o_last, o_data} !== exp_beat) begin
                        $display("FAIL rand_beat c=%0d got l=%b d=%h want l=%b d=%h",
                                 c, o_last, o_data, exp_beat[8], exp_beat[7:0]);
                        errs++;
                    end else pass_cnt++;
                end
            end
            if (i_valid && o_ready) begin
                for (int k = 0; k <= int'(i_len); k++)
                    sb.push_back({(k == int'(i_len)), w[k*8 +: 8]});
            end
        end
        total_cnt++;
        if (sb.size() != 0 || o_valid !== 1'b0)
            $display("FAIL rand_drain got pending=%0d v=%b want pending=0 v=0", sb.size(), o_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_full_word();
        next_cycle();
        test_back_to_back();
        next_cycle();
        test_backpressure();
        next_cycle();
        test_stall_last();
        test_reset_midword();
        next_cycle();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
